// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants for the issue-side register scoreboard
//
// Purpose: widths, register count and in-flight limits shared by the
// scoreboard top level and its per-register counters.
// Ports: none (package).

package reg_scoreboard_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int NREGS        = 32;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 3;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_counter.sv
// rtl/reg_scoreboard_counter.sv - per-register in-flight writer counter
//
// Purpose: counts the writers of one architectural register that have
// issued from ID but have not yet written back or been squashed.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   inc        an accepted writer of this register issues this cycle
//   decWb      MEM/WB writes this register back this cycle
//   decSq      a pending writer of this register is squashed this cycle
//   count      current number of in-flight writers
//   underflow  this cycle's update would take the count below zero
//   atMax      count has reached the saturation limit

module scoreboard_counter #(
  parameter int CNT_W        = reg_scoreboard_pkg::CNT_W,
  parameter int MAX_INFLIGHT = reg_scoreboard_pkg::MAX_INFLIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             decWb,
  input  logic             decSq,
  output logic [CNT_W-1:0] count,
  output logic             underflow,
  output logic             atMax
);

  // One extra bit holds the sign of the net update. The top level refuses
  // new writers once the count is at MAX_INFLIGHT, so count+inc never
  // exceeds 2**CNT_W-1 and the extra bit is set only by a true underflow.
  logic [CNT_W:0] sum;

  always_comb begin
    sum = {1'b0, count}
        + {{CNT_W{1'b0}}, inc}
        - {{CNT_W{1'b0}}, decWb}
        - {{CNT_W{1'b0}}, decSq};
    underflow = sum[CNT_W];
    atMax     = (count == CNT_W'(MAX_INFLIGHT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (underflow) begin
      count <= '0;
    end else begin
      count <= sum[CNT_W-1:0];
    end
  end

endmodule : scoreboard_counter

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue-side RAW hazard tracker for the 5-stage pipeline
//
// Purpose: tracks in-flight register writers from ID issue to MEM/WB
// writeback and stalls ID when a source operand has a pending producer
// that MEM/WB forwarding cannot supply this cycle.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   issue_valid/issue_regwrite    ID instruction request and its rd write
//   issue_rd, issue_rs1/rs2       destination and source registers
//   issue_uses_rs1/rs2            source operands actually read
//   wb_regwrite, wb_rd            MEM/WB writeback (same as forwarding unit)
//   squash_valid, squash_rd       issued writer flushed before writeback
//   stall                         hold IF/ID and PC, bubble into ID/EX
//   issue_accept                  issue_valid && !stall
//   busy_vec                      bit i set while register i has writers
//   err_underflow                 sticky: decrement of a zero counter

module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS        = reg_scoreboard_pkg::NREGS,
  parameter int CNT_W        = reg_scoreboard_pkg::CNT_W,
  parameter int MAX_INFLIGHT = reg_scoreboard_pkg::MAX_INFLIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_regwrite,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 issue_uses_rs1,
  input  logic                 issue_uses_rs2,
  input  logic [REG_IDX_W-1:0] issue_rs1,
  input  logic [REG_IDX_W-1:0] issue_rs2,
  input  logic                 wb_regwrite,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 squash_valid,
  input  logic [REG_IDX_W-1:0] squash_rd,
  output logic                 stall,
  output logic                 issue_accept,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 err_underflow
);

  logic [NREGS-1:0] hzVec;
  logic [NREGS-1:0] atMaxVec;
  logic [NREGS-1:0] underflowVec;
  logic             errUnderflow;

  // x0 is hard-wired zero: never busy, never a hazard, never saturated.
  assign busy_vec[0]     = 1'b0;
  assign hzVec[0]        = 1'b0;
  assign atMaxVec[0]     = 1'b0;
  assign underflowVec[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : gReg
    logic [CNT_W-1:0] cnt;
    logic             fwdOk;

    scoreboard_counter #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
    ) uCounter (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_accept && issue_regwrite && (issue_rd == REG_IDX_W'(g))),
      .decWb     (wb_regwrite && (wb_rd == REG_IDX_W'(g))),
      .decSq     (squash_valid && (squash_rd == REG_IDX_W'(g))),
      .count     (cnt),
      .underflow (underflowVec[g]),
      .atMax     (atMaxVec[g])
    );

    // Forwarding only covers the producer sitting in MEM/WB right now; if a
    // second writer of the same register is still behind it, ID must wait.
    assign fwdOk       = wb_regwrite && (wb_rd == REG_IDX_W'(g)) && (cnt == CNT_W'(1));
    assign hzVec[g]    = (cnt != '0) && !fwdOk;
    assign busy_vec[g] = (cnt != '0);
  end

  always_comb begin
    stall = 1'b0;
    if (!rst && issue_valid) begin
      stall = (issue_uses_rs1 && hzVec[issue_rs1])
           || (issue_uses_rs2 && hzVec[issue_rs2])
           || (issue_regwrite && (issue_rd != REG_ZERO) && atMaxVec[issue_rd]);
    end
    issue_accept = !rst && issue_valid && !stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      errUnderflow <= 1'b0;
    end else if (|underflowVec) begin
      errUnderflow <= 1'b1;
    end
  end

  assign err_underflow = errUnderflow;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard

module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issueValid;
  logic        issueRegwrite;
  logic [4:0]  issueRd;
  logic        issueUsesRs1;
  logic        issueUsesRs2;
  logic [4:0]  issueRs1;
  logic [4:0]  issueRs2;
  logic        wbRegwrite;
  logic [4:0]  wbRd;
  logic        squashValid;
  logic [4:0]  squashRd;
  logic        stall;
  logic        issueAccept;
  logic [31:0] busyVec;
  logic        errUnderflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issueValid),
    .issue_regwrite (issueRegwrite),
    .issue_rd       (issueRd),
    .issue_uses_rs1 (issueUsesRs1),
    .issue_uses_rs2 (issueUsesRs2),
    .issue_rs1      (issueRs1),
    .issue_rs2      (issueRs2),
    .wb_regwrite    (wbRegwrite),
    .wb_rd          (wbRd),
    .squash_valid   (squashValid),
    .squash_rd      (squashRd),
    .stall          (stall),
    .issue_accept   (issueAccept),
    .busy_vec       (busyVec),
    .err_underflow  (errUnderflow)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    issueValid    = 1'b0;
    issueRegwrite = 1'b0;
    issueRd       = 5'd0;
    issueUsesRs1  = 1'b0;
    issueUsesRs2  = 1'b0;
    issueRs1      = 5'd0;
    issueRs2      = 5'd0;
    wbRegwrite    = 1'b0;
    wbRd          = 5'd0;
    squashValid   = 1'b0;
    squashRd      = 5'd0;
  endtask

  // Advance one clock edge; inputs are then changed 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic writer(input logic [4:0] rd);
    idle();
    issueValid    = 1'b1;
    issueRegwrite = 1'b1;
    issueRd       = rd;
  endtask

  task automatic reader1(input logic [4:0] rs);
    idle();
    issueValid   = 1'b1;
    issueUsesRs1 = 1'b1;
    issueRs1     = rs;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    // Requests during reset must be refused and leave no trace.
    writer(5'd5);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_accept", 32'(issueAccept), 32'd0);
    tick();
    chk("rst_busy", busyVec, 32'h0);
    chk("rst_err", 32'(errUnderflow), 32'd0);

    // add x5, no hazards
    rst = 1'b0;
    writer(5'd5);
    #1;
    chk("add_accept", 32'(issueAccept), 32'd1);
    chk("add_stall", 32'(stall), 32'd0);
    tick();
    chk("add_busy", busyVec, 32'h0000_0020);

    // sub reads x5 while it is pending: stall holds until MEM/WB forwards
    reader1(5'd5);
    #1;
    chk("raw_stall0", 32'(stall), 32'd1);
    chk("raw_accept0", 32'(issueAccept), 32'd0);
    tick();
    #1;
    chk("raw_stall1", 32'(stall), 32'd1);
    wbRegwrite = 1'b1;
    wbRd       = 5'd5;
    #1;
    chk("raw_fwd_stall", 32'(stall), 32'd0);
    chk("raw_fwd_accept", 32'(issueAccept), 32'd1);
    tick();
    chk("raw_busy_clear", busyVec, 32'h0);

    // Three writers of x7, then saturation back-pressure
    writer(5'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sat_accept%0d", i), 32'(issueAccept), 32'd1);
      tick();
    end
    chk("sat_busy", busyVec, 32'h0000_0080);
    wbRegwrite = 1'b1;
    wbRd       = 5'd7;
    #1;
    chk("sat_stall", 32'(stall), 32'd1);
    chk("sat_refuse", 32'(issueAccept), 32'd0);
    tick();
    wbRegwrite = 1'b0;
    #1;
    chk("sat_after_wb_accept", 32'(issueAccept), 32'd1);
    tick();
    idle();
    wbRegwrite = 1'b1;
    wbRd       = 5'd7;
    tick();
    tick();
    chk("sat_drain_busy", busyVec, 32'h0000_0080);
    tick();
    chk("sat_drained", busyVec, 32'h0);
    chk("sat_no_err", 32'(errUnderflow), 32'd0);

    // Same-cycle inc and writeback on x9 nets to zero
    writer(5'd9);
    tick();
    wbRegwrite = 1'b1;
    wbRd       = 5'd9;
    #1;
    chk("x9_accept", 32'(issueAccept), 32'd1);
    tick();
    chk("x9_busy", busyVec, 32'h0000_0200);
    chk("x9_err", 32'(errUnderflow), 32'd0);
    // count must be exactly 1: forwarding from MEM/WB then covers a reader
    reader1(5'd9);
    #1;
    chk("x9_reader_stall", 32'(stall), 32'd1);
    wbRegwrite = 1'b1;
    wbRd       = 5'd9;
    #1;
    chk("x9_count_one", 32'(stall), 32'd0);
    tick();
    chk("x9_cleared", busyVec, 32'h0);

    // Writeback to an idle register is an underflow
    idle();
    wbRegwrite = 1'b1;
    wbRd       = 5'd12;
    tick();
    idle();
    chk("uf_err", 32'(errUnderflow), 32'd1);
    chk("uf_busy", busyVec, 32'h0);
    tick();
    chk("uf_sticky", 32'(errUnderflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("uf_rst_clear", 32'(errUnderflow), 32'd0);

    // x0 is never tracked
    writer(5'd0);
    issueUsesRs1 = 1'b1;
    issueRs1     = 5'd0;
    #1;
    chk("x0_stall", 32'(stall), 32'd0);
    tick();
    chk("x0_busy", busyVec, 32'h0);
    reader1(5'd0);
    #1;
    chk("x0_read_stall", 32'(stall), 32'd0);

    // Squash of a pending x3 writer
    writer(5'd3);
    tick();
    chk("sq_busy", busyVec, 32'h0000_0008);
    reader1(5'd3);
    squashValid = 1'b1;
    squashRd    = 5'd3;
    #1;
    chk("sq_stall_same_cycle", 32'(stall), 32'd1);
    tick();
    squashValid = 1'b0;
    #1;
    chk("sq_busy_clear", busyVec, 32'h0);
    chk("sq_reader_free", 32'(stall), 32'd0);
    chk("sq_no_err", 32'(errUnderflow), 32'd0);

    // rs2 path, operand-use gating, and a double decrement
    writer(5'd4);
    tick();
    tick();
    chk("rs2_busy", busyVec, 32'h0000_0010);
    idle();
    issueValid   = 1'b1;
    issueUsesRs2 = 1'b1;
    issueRs2     = 5'd4;
    #1;
    chk("rs2_stall", 32'(stall), 32'd1);
    issueUsesRs2 = 1'b0;
    #1;
    chk("rs2_unused", 32'(stall), 32'd0);
    idle();
    wbRegwrite  = 1'b1;
    wbRd        = 5'd4;
    squashValid = 1'b1;
    squashRd    = 5'd4;
    tick();
    idle();
    chk("dbl_dec_busy", busyVec, 32'h0);
    chk("dbl_dec_err", 32'(errUnderflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_scoreboard
